// File: rtl/capture_ctrl_pkg.sv
// Shared types and constants for the capture run controller.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Wide all-ones value; users slice it down to their counter width (up to 64 bits).
  localparam logic [63:0] NUM_SAT = '1;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample stream bundle between the sampler, the run controller and capture storage.
interface capture_if #(parameter int SDW = 32) ();

  logic [SDW-1:0] sti_tdata;
  logic           sti_trigger;
  logic           sti_tvalid;
  logic           sti_tready;

  logic [SDW-1:0] sto_tdata;
  logic           sto_trigger;
  logic           sto_tlast;
  logic           sto_tvalid;
  logic           sto_tready;

  modport master (
    input  sti_tdata, sti_trigger, sti_tvalid,
    output sti_tready,
    output sto_tdata, sto_trigger, sto_tlast, sto_tvalid,
    input  sto_tready
  );

  modport slave (
    output sti_tdata, sti_trigger, sti_tvalid,
    input  sti_tready,
    input  sto_tdata, sto_trigger, sto_tlast, sto_tvalid,
    output sto_tready
  );

endinterface

// File: rtl/capture_ctrl_str_reg.sv
// Generic single-stage valid/ready register slice with a hard flush.
module str_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  assign in_ready = ~out_valid | out_ready;

  // Flush drops the held word without waiting for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture run controller: arms on command, forwards pre-trigger samples, then a
// fixed number of post-trigger samples ending in tlast.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int SDW = 32,
  parameter int SNW = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_arm,
  input  logic           cmd_abort,
  input  logic [SNW-1:0] cfg_post,
  output logic           sts_armed,
  output logic           sts_run,
  output logic           sts_done,
  output logic [SNW-1:0] sts_num,
  capture_if.master      stream
);

  localparam logic [SNW-1:0] SAT = NUM_SAT[SNW-1:0];

  state_t         state;
  logic [SNW-1:0] post_r;
  logic [SNW-1:0] cnt;
  logic           forwarding;
  logic           slice_ready;
  logic           load;
  logic           is_trig;
  logic           is_last;
  logic [SDW+1:0] load_word;
  logic [SDW+1:0] out_word;
  logic [SNW-1:0] num_inc;

  assign forwarding = (state == ARMED) || (state == POST);
  assign stream.sti_tready = forwarding ? slice_ready : 1'b1;
  assign load = forwarding & stream.sti_tvalid & slice_ready & ~cmd_abort;
  assign is_trig = (state == ARMED) & stream.sti_trigger;
  // POST is only entered with post_r >= 1, so post_r-1 never wraps there.
  assign is_last = (is_trig & (post_r == '0))
                 | ((state == POST) & (cnt == post_r - 1'b1));
  assign load_word = {is_trig, is_last, stream.sti_tdata};
  assign num_inc = (sts_num == SAT) ? sts_num : sts_num + 1'b1;

  str_reg #(.DW(SDW + 2)) u_out (
    .clk       (clk),
    .rst       (rst),
    .flush     (cmd_abort),
    .in_data   (load_word),
    .in_valid  (load),
    .in_ready  (slice_ready),
    .out_data  (out_word),
    .out_valid (stream.sto_tvalid),
    .out_ready (stream.sto_tready)
  );

  assign {stream.sto_trigger, stream.sto_tlast, stream.sto_tdata} = out_word;

  // Status flags are written alongside the state so they always mirror it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      post_r    <= '0;
      cnt       <= '0;
      sts_num   <= '0;
      sts_armed <= 1'b0;
      sts_run   <= 1'b0;
      sts_done  <= 1'b0;
    end else if (cmd_abort) begin
      state     <= IDLE;
      cnt       <= '0;
      sts_armed <= 1'b0;
      sts_run   <= 1'b0;
      sts_done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (cmd_arm) begin
            state     <= ARMED;
            post_r    <= cfg_post;
            cnt       <= '0;
            sts_num   <= '0;
            sts_armed <= 1'b1;
            sts_run   <= 1'b1;
            sts_done  <= 1'b0;
          end
        end
        ARMED: begin
          if (load) begin
            sts_num <= num_inc;
            if (is_trig) begin
              sts_armed <= 1'b0;
              if (is_last) begin
                state    <= DONE;
                sts_run  <= 1'b0;
                sts_done <= 1'b1;
              end else begin
                state <= POST;
              end
            end
          end
        end
        POST: begin
          if (load) begin
            sts_num <= num_inc;
            cnt     <= cnt + 1'b1;
            if (is_last) begin
              state    <= DONE;
              sts_run  <= 1'b0;
              sts_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
